polyphase_commutator: RTL
=========================

// Module: polyphase_commutator
// PURPOSE
//  Parametrised polyphase decimator front-end with one clock domain.
//  Takes one signed sample per in_valid beat. Builds frames of PHASES consecutive samples.
//  Presents each frame in parallel as newest-first taps (z^0 .. z^-(PHASES-1)) with a one-cycle out_valid strobe.
//  Feeds the per-phase sub-filters of the IIR/FIR decimation path, replacing the fixed 3-phase, dual-clock delay block.
// PARAMETERS
//  WIDTH   11  sample width, signed two's complement
//  PHASES  3   decimation factor / number of output taps; legal range 2..16
// PORTS
//  clk        in   1                     system clock, rising edge
//  reset      in   1                     asynchronous, active-high reset
//  in_valid   in   1                     In is a valid sample this cycle
//  In         in   WIDTH                 signed input sample
//  sync       in   1                     frame realign; port exists only with POLY_COMM_SYNC_EN
//  out_valid  out  1                     Out[] holds a new frame; one-cycle pulse
//  Out        out  WIDTH x [0:PHASES-1]  signed taps; Out[k] = sample delayed by k within the frame
//  phase      out  $clog2(PHASES)        index of the next sample within the frame (0..PHASES-1)
// BEHAVIOUR
//  - Reset (async, active-high):
//    - Out[*] = 0, out_valid = 0, phase = 0.
//    - Delay-line registers dly[0:PHASES-2] = 0.
//  - Accepted sample = rising clk edge with in_valid=1.
//    - On each accepted sample: dly[0] <= In and dly[k] <= dly[k-1].
//    - phase increments by 1 and wraps PHASES-1 -> 0.
//  - Frame completion = accepted sample while phase == PHASES-1. On that edge:
//    - Out[0] <= In; Out[k] <= dly[k-1] for k = 1..PHASES-1.
//    - out_valid <= 1 for exactly one cycle; phase <= 0.
//  - Latency: Out and out_valid are valid the cycle after the frame's last sample is accepted.
//  - Out[] holds its value until the next frame completes.
//  - in_valid=0: In is ignored; dly, phase and Out hold; out_valid <= 0.
//  - Gaps of any length inside a frame are allowed. Frame content depends only on accepted samples.
//  - Arithmetic: pure data movement. No sign extension, rounding or saturation; bit-exact copy.
//  - Reset mid-frame: the partial frame is discarded and no out_valid is produced. The next accepted sample is phase 0.
//  - Back-to-back frames: out_valid may be high in consecutive-frame cycles at most once every PHASES cycles. No stall or backpressure exists.
//  - phase counter is $clog2(PHASES) bits wide. Values >= PHASES are unreachable.
// CONFIGURATION
//  - POLY_COMM_SYNC_EN defined: the sync input port exists.
//    - sync=1 with in_valid=1: the sample is taken as phase 0 and the partial frame is discarded.
//    - On that edge: dly[0] <= In, dly[k>0] <= 0, phase <= 1, and no out_valid.
//    - For PHASES=2, phase <= 1 completes normally on the next accepted sample.
//    - sync has priority over frame completion at phase == PHASES-1: no out_valid that cycle.
//    - sync=1 with in_valid=0: ignored.
//  - POLY_COMM_SYNC_EN undefined: no sync port. Frame alignment is set only by reset.
// TESTING  (WIDTH=11, PHASES=3 unless noted)
//  1. Hold reset with in_valid=1 and In=5 -> Out={0,0,0}, out_valid=0, phase=0. After release, the first accepted sample is phase 0.
//  2. Continuous in_valid with In=1,2,3,4,5,6 -> out_valid pulses after the 3rd and 6th samples. Out={3,2,1} then {6,5,4}.
//  3. In=1, then 2 idle cycles with In=99 and in_valid=0, then 2,3 -> a single frame Out={3,2,1}. The value 99 never appears.
//  4. Signed extremes In=-1024,1023,-1 -> Out[0]=-1, Out[1]=1023, Out[2]=-1024 bit-exact.
//  5. Accept 1,2, assert reset for 1 cycle, then accept 7,8,9 -> one frame Out={9,8,7}. No out_valid from the partial frame.
//  6. (POLY_COMM_SYNC_EN) Accept 1,2, then In=10 with sync=1, then 11,12 -> one frame Out={12,11,10}. No earlier pulse.
//     Repeat with PHASES=4 and check the wrap from phase 3 to 0.

Source files
------------

// File: rtl/polyphase_commutator.sv
// Polyphase decimator front-end: gathers PHASES accepted samples into a newest-first tap frame.
// Optional frame-realign input `sync` is present only when POLY_COMM_SYNC_EN is defined.
module polyphase_commutator #(
    parameter int unsigned WIDTH  = 11,
    parameter int unsigned PHASES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] In,
`ifdef POLY_COMM_SYNC_EN
    input  logic                    sync,
`endif
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] Out [0:PHASES-1],
    output logic [$clog2(PHASES)-1:0] phase
);

    localparam int unsigned PW = $clog2(PHASES);
    localparam int          NP = int'(PHASES);
    localparam logic [PW-1:0] LastPhase = PW'(PHASES - 1);

    logic signed [WIDTH-1:0] r_dly [0:PHASES-2];
    logic signed [WIDTH-1:0] r_out [0:PHASES-1];
    logic [PW-1:0]           r_phase;
    logic                    r_out_valid;
    logic                    w_sync;
    logic                    w_last;

`ifdef POLY_COMM_SYNC_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    assign w_last = (r_phase == LastPhase);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NP - 1; k++) r_dly[k] <= '0;
            for (int k = 0; k < NP; k++) r_out[k] <= '0;
            r_phase     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
                r_dly[0] <= In;
                if (w_sync) begin
                    // Realign: this sample becomes phase 0, older partial-frame data is dropped
                    for (int k = 1; k < NP - 1; k++) r_dly[k] <= '0;
                    r_phase <= PW'(1);
                end else begin
                    for (int k = 1; k < NP - 1; k++) r_dly[k] <= r_dly[k-1];
                    if (w_last) begin
                        r_out[0] <= In;
                        for (int k = 1; k < NP; k++) r_out[k] <= r_dly[k-1];
                        r_out_valid <= 1'b1;
                        r_phase     <= '0;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Out       = r_out;
    assign phase     = r_phase;

endmodule
